// File: rtl/bft_leaf_egress_relay_pkg.sv
// Packet field layout for the leaf interface packets carried into the BFT.
// Shared with the leaf_interface users.
package bft_leaf_egress_relay_pkg;

  localparam int VALID_BIT    = 48;
  localparam int LEAF_MSB     = 47;
  localparam int LEAF_LSB     = 43;
  localparam int PORT_MSB     = 42;
  localparam int PORT_LSB     = 39;
  localparam int ADDR_MSB     = 38;
  localparam int ADDR_LSB     = 32;
  localparam int PAYLOAD_BITS = 32;

endpackage

// File: rtl/bft_leaf_egress_relay_fifo.sv
// relay_sync_fifo: synchronous FIFO on distributed RAM with a registered occupancy count.
// Writes on full and reads on empty are ignored.
module relay_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // No reset on the storage itself: only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr && !reset) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bft_leaf_egress_relay.sv
// Egress relay between a leaf page and the BFT tree: FIFO plus a single output stage,
// with resend flow control, a delivered-packet counter and a sticky overflow flag.
module bft_leaf_egress_relay
  import bft_leaf_egress_relay_pkg::*;
#(
  parameter int PACKET_BITS = 49,
  parameter int DEPTH       = 8,
  parameter int SKID        = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] din_leaf_page2relay,
  output logic                   resend,
  output logic [PACKET_BITS-1:0] dout_leaf_relay2bft,
  input  logic                   bft_ready,
  output logic [31:0]            pkt_cnt,
  output logic                   overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic [VALID_BIT-1:0] head;
  logic [VALID_BIT-1:0] out_data;
  logic                 out_full;
  logic                 transfer;
  logic                 load;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        count_next;
  logic                 resend_next;
  logic                 resend_q;
  logic [31:0]          pkt_cnt_q;
  logic                 overflow_q;

  assign in_valid = din_leaf_page2relay[VALID_BIT];
  assign transfer = out_full && bft_ready;
  assign load     = (!out_full || transfer) && !fifo_empty;

  relay_sync_fifo #(
    .WIDTH (VALID_BIT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_valid),
    .wr_data (din_leaf_page2relay[VALID_BIT-1:0]),
    .rd_en   (load),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Threshold is evaluated on the post-edge occupancy so resend reacts in one cycle.
  always_comb begin
    count_next = fifo_count;
    if (in_valid && !fifo_full) count_next = count_next + CW'(1);
    if (load)                   count_next = count_next - CW'(1);
    resend_next = (DEPTH - int'(count_next)) > SKID;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_full   <= 1'b0;
      out_data   <= '0;
      pkt_cnt_q  <= '0;
      overflow_q <= 1'b0;
      resend_q   <= 1'b0;
    end else begin
      if (load) begin
        out_full <= 1'b1;
        out_data <= head;
      end else if (transfer) begin
        out_full <= 1'b0;
      end
      if (transfer) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (in_valid && fifo_full) overflow_q <= 1'b1;
      resend_q <= resend_next;
    end
  end

  assign dout_leaf_relay2bft = {out_full, out_data};
  assign resend              = resend_q;
  assign pkt_cnt             = pkt_cnt_q;
  assign overflow            = overflow_q;

endmodule

// File: tb/tb_bft_leaf_egress_relay.sv
// Directed and random stimulus for bft_leaf_egress_relay, checked cycle by cycle
// against a queue-based reference model.
module tb_bft_leaf_egress_relay;

  localparam int DEPTH = 8;
  localparam int SKID  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [48:0] din = '0;
  logic        resend;
  logic [48:0] dout;
  logic        bft_ready = 1'b0;
  logic [31:0] pkt_cnt;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [47:0] mq[$];
  logic        m_valid;
  logic [47:0] m_data;
  logic [31:0] m_pkt;
  logic        m_ovf;
  logic        m_resend;

  bft_leaf_egress_relay #(
    .PACKET_BITS (49),
    .DEPTH       (DEPTH),
    .SKID        (SKID)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .din_leaf_page2relay (din),
    .resend              (resend),
    .dout_leaf_relay2bft (dout),
    .bft_ready           (bft_ready),
    .pkt_cnt             (pkt_cnt),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] rnd48();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = $urandom;
    return {a[15:0], b};
  endfunction

  task automatic check();
    n_vec++;
    assert (dout === {m_valid, m_data}) else begin
      n_err++;
      $error("FAIL dout got=%h exp=%h", dout, {m_valid, m_data});
    end
    n_vec++;
    assert (resend === m_resend) else begin
      n_err++;
      $error("FAIL resend got=%b exp=%b", resend, m_resend);
    end
    n_vec++;
    assert (pkt_cnt === m_pkt) else begin
      n_err++;
      $error("FAIL pkt_cnt got=%h exp=%h", pkt_cnt, m_pkt);
    end
    n_vec++;
    assert (overflow === m_ovf) else begin
      n_err++;
      $error("FAIL overflow got=%b exp=%b", overflow, m_ovf);
    end
    n_vec++;
    assert (dut.fifo_count === 4'(mq.size())) else begin
      n_err++;
      $error("FAIL count got=%0d exp=%0d", dut.fifo_count, mq.size());
    end
  endtask

  // One clock: drive inputs, advance the model to the post-edge state, compare at negedge.
  task automatic step(input bit v, input logic [47:0] d, input bit rdy, input bit rst);
    bit xfer;
    bit ld;
    bit accept;
    din       = {v, d};
    bft_ready = rdy;
    reset     = rst;
    if (rst) begin
      mq.delete();
      m_valid  = 1'b0;
      m_data   = '0;
      m_pkt    = '0;
      m_ovf    = 1'b0;
      m_resend = 1'b0;
    end else begin
      xfer   = m_valid && rdy;
      ld     = (!m_valid || xfer) && (mq.size() > 0);
      accept = v && (mq.size() < DEPTH);
      if (v && !accept) m_ovf = 1'b1;
      if (xfer) m_pkt = m_pkt + 32'd1;
      if (ld) m_data = mq.pop_front();
      m_valid = ld ? 1'b1 : (xfer ? 1'b0 : m_valid);
      if (accept) mq.push_back(d);
      m_resend = (DEPTH - mq.size()) > SKID;
    end
    @(posedge clk);
    @(negedge clk);
    check();
  endtask

  initial begin
    // reset, then resend must rise on the first free cycle
    step(1'b1, rnd48(), 1'b1, 1'b1);
    step(1'b1, rnd48(), 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // single packet, 2-cycle latency
    step(1'b1, 48'h0800_0000_00AB, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    assert (dout === 49'h1_0800_0000_00AB) else begin
      n_err++;
      $error("FAIL single_pkt got=%h exp=%h", dout, 49'h1_0800_0000_00AB);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    assert (pkt_cnt === 32'd1) else begin
      n_err++;
      $error("FAIL single_cnt got=%0d exp=1", pkt_cnt);
    end

    // backpressure: 6 packets held, then released in order
    for (int i = 0; i < 6; i++) step(1'b1, rnd48(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

    // overflow: 10 forced packets, 9 held, then drain
    for (int i = 0; i < 10; i++) step(1'b1, rnd48(), 1'b0, 1'b0);
    n_vec++;
    assert (overflow === 1'b1) else begin
      n_err++;
      $error("FAIL ovf_flag got=%b exp=1", overflow);
    end
    for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1, 1'b0);

    // full FIFO with simultaneous read and write attempt
    step(1'b1, '0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, rnd48(), 1'b0, 1'b0);
    step(1'b1, rnd48(), 1'b1, 1'b0);
    n_vec++;
    assert (dut.fifo_count === 4'd7 && overflow === 1'b1) else begin
      n_err++;
      $error("FAIL full_rw count=%0d ovf=%b exp count=7 ovf=1", dut.fifo_count, overflow);
    end
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

    // mid-stream reset discards buffered packets
    for (int i = 0; i < 4; i++) step(1'b1, rnd48(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    assert (dout === '0) else begin
      n_err++;
      $error("FAIL rst_dout got=%h exp=0", dout);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // pkt_cnt wrap
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt_q;
    m_pkt = 32'hFFFF_FFFF;
    step(1'b1, rnd48(), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    assert (pkt_cnt === 32'd0) else begin
      n_err++;
      $error("FAIL wrap got=%h exp=0", pkt_cnt);
    end

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), rnd48(), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
